// File: rtl/gpio_write_arbiter.sv
// gpio_write_arbiter: shares one GPIO write port between NUM_REQ requesters.
// Round-robin winner gets a masked read-modify-write of the port, the port is
// held for SETTLE_CYCLES, then the read port is sampled and returned with a
// per-requester completion pulse.
//
// state  | meaning
// IDLE   | waiting for any request; winner latched and port updated on exit
// GNT    | one-cycle grant pulse to the latched winner
// SETTLE | port held stable while the settle down-counter runs out
// DONE   | one-cycle completion pulse; read port captured on entry
module gpio_write_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int WRITE_PORT_WIDTH = 4,
  parameter int READ_PORT_WIDTH  = 4,
  parameter int SETTLE_CYCLES    = 2,
  parameter logic [WRITE_PORT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ*WRITE_PORT_WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ*WRITE_PORT_WIDTH-1:0]   req_mask_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    done_o,
  output logic [READ_PORT_WIDTH-1:0]            read_sample_o,
  output logic                                  busy_o,
  output logic [WRITE_PORT_WIDTH-1:0]           write_port_o,
  input  logic [READ_PORT_WIDTH-1:0]            read_port_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
  // Counter is loaded with N-1 so that SETTLE lasts exactly N cycles.
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              win_q, win_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [WRITE_PORT_WIDTH-1:0]   port_q, port_d;
  logic [READ_PORT_WIDTH-1:0]    sample_q, sample_d;

  logic [IDX_W-1:0]              win_idx;
  logic [IDX_W-1:0]              cand_idx;
  logic                          found;
  logic [WRITE_PORT_WIDTH-1:0]   win_data;
  logic [WRITE_PORT_WIDTH-1:0]   win_mask;
  logic [NUM_REQ-1:0]            win_onehot;

  // Round-robin search starting one past the last winner, ascending with wrap.
  always_comb begin
    win_idx  = win_q;
    cand_idx = win_q;
    found    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(win_q) + i) % NUM_REQ);
      if (!found && req_i[cand_idx]) begin
        win_idx = cand_idx;
        found   = 1'b1;
      end
    end
  end

  // Select the candidate winner's data and mask slices.
  always_comb begin
    win_data = '0;
    win_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_data = req_data_i[k*WRITE_PORT_WIDTH +: WRITE_PORT_WIDTH];
        win_mask = req_mask_i[k*WRITE_PORT_WIDTH +: WRITE_PORT_WIDTH];
      end
    end
  end

  // Next-state, settle timer, port update and read sampling.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    sample_d = sample_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_GNT;
          win_d   = win_idx;
          port_d  = (port_q & ~win_mask) | (win_data & win_mask);
        end
      end
      S_GNT: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d  = S_DONE;
          sample_d = read_port_i;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d  = S_DONE;
          sample_d = read_port_i;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      win_q    <= LAST_RESET;
      cnt_q    <= 8'd0;
      port_q   <= RESET_VALUE;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      sample_q <= sample_d;
    end
  end

  assign win_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
  assign gnt_o         = (state_q == S_GNT)  ? win_onehot : '0;
  assign done_o        = (state_q == S_DONE) ? win_onehot : '0;
  assign busy_o        = (state_q != S_IDLE);
  assign write_port_o  = port_q;
  assign read_sample_o = sample_q;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Bench for gpio_write_arbiter: two instances (settle 2 and settle 0), each
// with a transaction-level reference model feeding grant/done scoreboards.
module tb_gpio_write_arbiter;

  localparam int NR = 4;
  localparam int WW = 4;
  localparam int RW = 4;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = (g == 0) ? 2 : 0;
    localparam logic [WW-1:0] RV = (g == 0) ? 4'h0 : 4'h9;

    logic             rst;
    logic [NR-1:0]    req, gnt, done;
    logic [NR*WW-1:0] data, mask;
    logic [RW-1:0]    rp, rs;
    logic             busy;
    logic [WW-1:0]    wp;

    exp_t          gq[$];
    exp_t          dq[$];
    exp_t          e;
    int            cyc = 0;
    int            next_free, last, w, c, pend_cyc, pend_idx;
    bit            pend, hold, fin;
    logic [WW-1:0] mport, dw, mw;
    logic [RW-1:0] mrs;

    gpio_write_arbiter #(
      .NUM_REQ(NR), .WRITE_PORT_WIDTH(WW), .READ_PORT_WIDTH(RW),
      .SETTLE_CYCLES(S), .RESET_VALUE(RV)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(data), .req_mask_i(mask),
      .gnt_o(gnt), .done_o(done), .read_sample_o(rs), .busy_o(busy),
      .write_port_o(wp), .read_port_i(rp)
    );

    task automatic model_reset();
      gq.delete();
      dq.delete();
      last      = NR - 1;
      next_free = 0;
      mport     = RV;
      mrs       = '0;
      pend      = 1'b0;
    endtask

    // Reference model: one transaction occupies the port for S+3 cycles.
    initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (pend && cyc == pend_cyc) begin
          mrs = rp;
          dq.push_back('{cyc, pend_idx, 32'(rp)});
          pend = 1'b0;
        end
        if (cyc >= next_free && req != '0) begin
          w = -1;
          for (int i = 1; i <= NR; i++) begin
            c = (last + i) % NR;
            if (w < 0 && req[c]) w = c;
          end
          dw    = data[w*WW +: WW];
          mw    = mask[w*WW +: WW];
          mport = (mport & ~mw) | (dw & mw);
          gq.push_back('{cyc, w, 32'(mport)});
          last      = w;
          pend      = 1'b1;
          pend_cyc  = cyc + 1 + S;
          pend_idx  = w;
          next_free = cyc + S + 3;
        end
      end
    end

    // Monitor: compare DUT outputs against model state and scoreboards.
    initial forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_port", 32'(wp), 32'(RV));
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sample", 32'(rs), 0);
      end else begin
        chk("port", 32'(wp), 32'(mport));
        chk("sample", 32'(rs), 32'(mrs));
        chk("busy", 32'(busy), 32'(cyc < next_free - 1));
        chk("gnt_done_overlap", 32'((gnt != '0) && (done != '0)), 0);
        if (gnt != '0) begin
          if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
          else begin
            e = gq.pop_front();
            chk("gnt_cycle", cyc, e.cyc);
            chk("gnt_who", 32'(gnt), 32'(1) << e.idx);
            chk("gnt_port", 32'(wp), e.val);
          end
        end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
          e = gq.pop_front();
          chk("gnt_missing", 32'(gnt), 32'(1) << e.idx);
        end
        if (done != '0) begin
          if (dq.size() == 0) chk("done_unexpected", 32'(done), 0);
          else begin
            e = dq.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_who", 32'(done), 32'(1) << e.idx);
            chk("done_sample", 32'(rs), e.val);
          end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
          e = dq.pop_front();
          chk("done_missing", 32'(done), 32'(1) << e.idx);
        end
      end
    end

    task automatic step();
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (req[k] && gnt[k] && !hold) req[k] = 1'b0;
        if (!req[k]) begin
          data[k*WW +: WW] = WW'($urandom);
          mask[k*WW +: WW] = WW'($urandom);
        end
      end
      rp = RW'($urandom);
    endtask

    task automatic raise(input int k, input logic [WW-1:0] d, input logic [WW-1:0] m);
      data[k*WW +: WW] = d;
      mask[k*WW +: WW] = m;
      req[k] = 1'b1;
    endtask

    task automatic wait_quiet();
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while ((req != '0 || busy) && n < 200);
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL quiet_timeout: busy=%0b req=%0h after %0d cycles", busy, req, n);
      end
    endtask

    // Stimulus: directed cases, held requests, random traffic, mid-flight reset.
    initial begin
      int n;
      rst = 1'b1; req = '0; data = '0; mask = '0; rp = '0; hold = 1'b0; fin = 1'b0;
      model_reset();
      repeat (3) step();
      rst = 1'b0;

      step(); raise(0, 4'hA, 4'hF); wait_quiet();
      chk("dir_full_write", 32'(wp), 32'h0A);
      step(); raise(0, 4'hC, 4'hF); wait_quiet();
      chk("dir_start_c", 32'(wp), 32'h0C);
      step(); raise(1, 4'h3, 4'h3); wait_quiet();
      chk("dir_masked", 32'(wp), 32'h0F);
      step(); raise(1, 4'h0, 4'h0); wait_quiet();
      chk("dir_zero_mask", 32'(wp), 32'h0F);

      step(); hold = 1'b1; req = '1;
      repeat (5 * (S + 3)) step();
      hold = 1'b0; req = '0;
      wait_quiet();

      for (int t = 0; t < 400; t++) begin
        step();
        for (int k = 0; k < NR; k++) begin
          if (!req[k] && $urandom_range(3) == 0) raise(k, WW'($urandom), WW'($urandom));
          else if (req[k] && !gnt[k] && $urandom_range(15) == 0) req[k] = 1'b0;
        end
      end
      req = '0;
      wait_quiet();

      step(); raise(2, 4'h5, 4'hF);
      n = 0;
      do begin
        step();
        n++;
      end while (!busy && n < 20);
      if (S > 0) step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_port", 32'(wp), 32'(RV));
      chk("async_busy", 32'(busy), 0);
      req = '0;
      step(); step();
      rst = 1'b0;
      step(); raise(3, 4'hC, 4'hF); raise(0, 4'h3, 4'hF);
      wait_quiet();

      step();
      chk("grant_queue_empty", gq.size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_inst[0].fin && g_inst[1].fin);
      #500000;
    join_any
    disable fork;
    if (!(g_inst[0].fin && g_inst[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: instances did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
